mi_demux: RTL and testbench
===========================

# mi_demux

Parametrised, registered successor to the 1-to-5 master-input fanout in the DMA datapath. It steers one valid/ready input stream to one of NCH channel outputs, using the arbiter's grant vector. The grant is latched per packet and held until the last beat. Each channel has a one-entry output register, so every output is registered and backpressure is honoured per channel. The block sits between the DMA read-data path and the per-channel consumers.

## Interface
- DW, 32, data width in bits
- NCH, 5, number of output channels (2..16)

- wb_clk_i  in  1  clock
- wb_rst_n  in  1  asynchronous active-low reset
- gnt  in  NCH  grant from arbiter; sampled only when a packet starts
- in_data  in  DW  input beat
- in_valid  in  1  input beat valid
- in_last  in  1  final beat of packet
- in_ready  out  1  input beat accepted when in_valid & in_ready
- out_data  out  NCH*DW  channel k occupies bits [k*DW +: DW]
- out_valid  out  NCH  per-channel beat valid
- out_last  out  NCH  per-channel last flag
- out_ready  in  NCH  per-channel consumer ready
- busy  out  1  packet lock held
- sel_err  out  1  one-cycle pulse: multi-bit grant seen at lock (single-select build only)

## Operation
- The packet FSM has two states.
  - IDLE → LOCK when in_valid=1 and gnt≠0. In that cycle the selection is computed from gnt and stored in sel_q. The first beat may be accepted in the same cycle.
  - LOCK → IDLE when a beat with in_last=1 is accepted.
  - In IDLE with in_valid=1 and gnt=0: in_ready=0; the block waits without consuming.
- Effective selection: sel = (state==IDLE) ? decode(gnt) : sel_q. Changes on gnt during LOCK are ignored.
- Channel slot k can accept when ~out_valid[k] | out_ready[k].
- in_ready = (sel≠0) & (AND of can-accept over all k with sel[k]=1).
- On an accepted beat, every selected slot loads in_data and in_last, and sets out_valid.
- A slot clears out_valid when out_ready[k]=1 and no new load arrives in that cycle.
- Unselected slots keep their contents. They continue draining under their own out_ready.
- busy = (state==LOCK).

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, sel_q=0, state=IDLE, busy=0, sel_err=0. in_ready is combinational and 0 while sel=0.
- Latency: an accepted beat appears on out_data/out_valid one cycle later.
- Throughput: one beat per cycle when the selected consumer holds out_ready=1.
- Single-beat packets (in_valid & in_last on the lock cycle): lock and release happen in the same cycle, and the state stays IDLE.
- A new packet may lock the cycle after a last beat is accepted, even while the previous channel is still draining.
- Reset asserted mid-packet: all slots are flushed immediately and the partial packet is discarded, with no tail emitted.

## Configuration
- MI_DEMUX_BCAST_EN defined:
  - A multi-bit gnt selects every set bit (broadcast).
  - in_ready waits for all selected slots, and each beat loads all of them in the same cycle.
  - sel_err is tied to 0.
- MI_DEMUX_BCAST_EN undefined:
  - decode(gnt) keeps only the lowest set bit.
  - sel_err pulses for one cycle on a lock cycle where popcount(gnt)>1.

## Structure
- Package mi_pkg: the FSM state enum (MI_IDLE, MI_LOCK), the lowest-set-bit function, and the popcount function.
- Sub-module mi_demux_slot, instantiated NCH times. It is a one-entry output register with load, data, last and ready inputs, and valid, last and data outputs.

## Test plan
- After reset: gnt=5'b00100, 3-beat packet 0xA0,0xA1,0xA2 (last on 0xA2), out_ready all 1 → channel 2 outputs the beats on cycles +1,+2,+3, out_last[2] on 0xA2, and every other out_valid stays 0.
- gnt changes to 5'b00001 mid-packet → the remaining beats still go to channel 2. A following packet goes to channel 0.
- out_ready[2]=0 for 3 cycles during a packet → in_ready=0 for those cycles, channel 2 data is held stable, and no beat is lost or duplicated.
- gnt=0 with in_valid=1 for 4 cycles → in_ready=0 and busy=0 throughout. Raising gnt=5'b00010 then accepts the beat on the next cycle.
- gnt=5'b10010, 2-beat packet:
  - Without the macro: channel 1 only, sel_err=1 for exactly one cycle.
  - With MI_DEMUX_BCAST_EN: channels 1 and 4 both receive both beats. Stalling out_ready[4] stalls in_ready.
- wb_rst_n pulsed low after beat 1 of 3 → all out_valid=0 and state=IDLE. Channel 2 emits no further beats after reset release.

Source files
------------

// File: rtl/mi_pkg.sv
// Shared types and helpers for the mi_demux channel fanout.
// Grant decode helpers work on a 16-bit vector, which is the maximum channel count.
package mi_pkg;

  localparam int unsigned MI_MAX_CH = 16;

  typedef enum logic {
    MI_IDLE = 1'b0,
    MI_LOCK = 1'b1
  } mi_state_e;

  // Isolates the lowest set bit: two's complement trick, zero stays zero.
  function automatic logic [MI_MAX_CH-1:0] mi_lowest_set(input logic [MI_MAX_CH-1:0] vec);
    logic [MI_MAX_CH-1:0] res;
    res = vec & (~vec + 16'd1);
    return res;
  endfunction

  function automatic logic [4:0] mi_popcount(input logic [MI_MAX_CH-1:0] vec);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < MI_MAX_CH; i++) begin
      cnt = cnt + {4'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mi_demux_slot.sv
// One-entry output register for a single mi_demux channel.
// A load always wins over a drain in the same cycle.
module mi_demux_slot
  import mi_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic          last_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [DW-1:0] data_q, data_d;

  // Next-state: load new beat, else drain on ready, else hold.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      last_d  = last_i;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= {DW{1'b0}};
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mi_demux.sv
// Packet-locked 1-to-NCH stream demux with registered per-channel outputs.
// Define MI_DEMUX_BCAST_EN to broadcast on multi-bit grants; otherwise lowest grant bit wins.
module mi_demux
  import mi_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned NCH = 5
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic [NCH-1:0]    gnt,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  output logic [NCH-1:0]    out_last,
  input  logic [NCH-1:0]    out_ready,
  output logic              busy,
  output logic              sel_err
);

  mi_state_e      state_q, state_d;
  logic [NCH-1:0] sel_q, sel_d;
  logic [NCH-1:0] sel_dec_s;
  logic [NCH-1:0] sel_s;
  logic [NCH-1:0] can_acc_s;
  logic [NCH-1:0] load_s;
  logic [NCH-1:0] out_valid_s;
  logic           in_ready_s;
  logic           accept_s;
  logic           lock_start_s;

`ifdef MI_DEMUX_BCAST_EN
  assign sel_dec_s = gnt;
  assign sel_err   = 1'b0;
`else
  logic [MI_MAX_CH-1:0] gnt_ext_s;
  logic [MI_MAX_CH-1:0] lsb_ext_s;
  logic                 multi_s;
  logic                 sel_err_q, sel_err_d;
  logic                 unused_lsb_s;

  // Single-select decode: widen the grant and keep only its lowest set bit.
  always_comb begin
    gnt_ext_s = {MI_MAX_CH{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      gnt_ext_s[k] = gnt[k];
    end
    lsb_ext_s = mi_lowest_set(gnt_ext_s);
    sel_dec_s = lsb_ext_s[NCH-1:0];
    multi_s   = (mi_popcount(gnt_ext_s) > 5'd1);
    sel_err_d = lock_start_s & multi_s;
  end

  assign unused_lsb_s = ^lsb_ext_s;

  // Registered one-cycle pulse flagging an ambiguous grant at lock time.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

  // Selection, per-slot acceptance and input handshake.
  always_comb begin
    if (state_q == MI_IDLE) begin
      sel_s = sel_dec_s;
    end else begin
      sel_s = sel_q;
    end
    can_acc_s    = ~out_valid_s | out_ready;
    in_ready_s   = (sel_s != {NCH{1'b0}}) & (&(~sel_s | can_acc_s));
    accept_s     = in_valid & in_ready_s;
    load_s       = sel_s & {NCH{accept_s}};
    lock_start_s = (state_q == MI_IDLE) & in_valid & (gnt != {NCH{1'b0}});
  end

  // Packet FSM next state; a last beat accepted on the lock cycle never leaves IDLE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      MI_IDLE: begin
        if (lock_start_s) begin
          sel_d = sel_dec_s;
          if (accept_s & in_last) begin
            state_d = MI_IDLE;
          end else begin
            state_d = MI_LOCK;
          end
        end else begin
          state_d = MI_IDLE;
        end
      end
      MI_LOCK: begin
        if (accept_s & in_last) begin
          state_d = MI_IDLE;
        end else begin
          state_d = MI_LOCK;
        end
      end
      default: begin
        state_d = MI_IDLE;
        sel_d   = {NCH{1'b0}};
      end
    endcase
  end

  // Packet lock registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= MI_IDLE;
      sel_q   <= {NCH{1'b0}};
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    mi_demux_slot #(
      .DW(DW)
    ) u_slot (
      .clk_i   (wb_clk_i),
      .rst_ni  (wb_rst_n),
      .load_i  (load_s[k]),
      .data_i  (in_data),
      .last_i  (in_last),
      .ready_i (out_ready[k]),
      .valid_o (out_valid_s[k]),
      .last_o  (out_last[k]),
      .data_o  (out_data[k*DW +: DW])
    );
  end

  assign out_valid = out_valid_s;
  assign in_ready  = in_ready_s;
  assign busy      = (state_q == MI_LOCK);

endmodule

// File: tb/tb_mi_demux.sv
// Directed scoreboard bench for mi_demux (DW=32, NCH=5); honours MI_DEMUX_BCAST_EN.
module tb_mi_demux;

  localparam int DW  = 32;
  localparam int NCH = 5;

  logic              wb_clk_i;
  logic              wb_rst_n;
  logic [NCH-1:0]    gnt;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_last;
  logic [NCH-1:0]    out_ready;
  logic              busy;
  logic              sel_err;

  int n_assert = 0;
  int n_fail   = 0;
  int serr_cnt = 0;
  int pop_cnt [NCH];
  logic [NCH-1:0] exp_mask;
  logic [DW:0]    exp_q [NCH][$];

  mi_demux #(.DW(DW), .NCH(NCH)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_n  (wb_rst_n),
    .gnt       (gnt),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .sel_err   (sel_err)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push accepted beats for the intended channels, pop on consumer handshakes.
  always @(negedge wb_clk_i) begin
    if (wb_rst_n) begin
      if (sel_err === 1'b1) serr_cnt++;
      if (in_valid && in_ready) begin
        for (int k = 0; k < NCH; k++)
          if (exp_mask[k]) exp_q[k].push_back({in_last, in_data});
      end
      for (int k = 0; k < NCH; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("unexpected_beat_ch%0d", k), {31'd0, out_last[k], out_data[k*DW +: DW]}, 64'hDEAD);
          end else begin
            logic [DW:0] e;
            e = exp_q[k].pop_front();
            pop_cnt[k]++;
            check($sformatf("beat_ch%0d", k), {31'd0, out_last[k], out_data[k*DW +: DW]}, {31'd0, e});
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    logic got;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    got      = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge wb_clk_i);
      if (in_ready === 1'b1) got = 1'b1;
      @(posedge wb_clk_i);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("accept_timeout", {63'd0, got}, 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check_drained(input string tag);
    for (int k = 0; k < NCH; k++)
      check($sformatf("%s_q%0d", tag, k), 64'(exp_q[k].size()), 64'd0);
  endtask

  initial begin
    wb_rst_n  = 1'b0;
    gnt       = 5'b00000;
    in_data   = 32'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 5'b11111;
    exp_mask  = 5'b00000;
    for (int k = 0; k < NCH; k++) pop_cnt[k] = 0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_out_valid", {59'd0, out_valid}, 64'd0);
    check("rst_out_last", {59'd0, out_last}, 64'd0);
    check("rst_out_data", {63'd0, |out_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_sel_err", {63'd0, sel_err}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    wb_rst_n = 1'b1;
    idle_cycles(2);

    // Basic 3-beat packet to channel 2 with one-cycle latency.
    gnt = 5'b00100; exp_mask = 5'b00100;
    send_beat(32'hA0, 1'b0);
    check("lat_valid", {59'd0, out_valid}, 64'b00100);
    check("lat_data", {32'd0, out_data[2*DW +: DW]}, 64'hA0);
    check("lock_busy", {63'd0, busy}, 64'd1);
    send_beat(32'hA1, 1'b0);
    send_beat(32'hA2, 1'b1);
    check("last_flag", {63'd0, out_last[2]}, 64'd1);
    idle_cycles(3);
    check_drained("t1");
    check("t1_pops", 64'(pop_cnt[2]), 64'd3);
    check("t1_busy", {63'd0, busy}, 64'd0);

    // Grant change mid-packet is ignored; next packet follows the new grant.
    send_beat(32'hB0, 1'b0);
    gnt = 5'b00001;
    send_beat(32'hB1, 1'b0);
    send_beat(32'hB2, 1'b1);
    exp_mask = 5'b00001;
    send_beat(32'hC0, 1'b0);
    send_beat(32'hC1, 1'b1);
    idle_cycles(3);
    check_drained("t2");
    check("t2_pops_ch2", 64'(pop_cnt[2]), 64'd6);
    check("t2_pops_ch0", 64'(pop_cnt[0]), 64'd2);

    // Backpressure on channel 2 for three cycles.
    gnt = 5'b00100; exp_mask = 5'b00100;
    send_beat(32'hD0, 1'b0);
    out_ready = 5'b11011;
    in_valid = 1'b1; in_data = 32'hD1;
    repeat (3) begin
      @(negedge wb_clk_i);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_hold", {32'd0, out_data[2*DW +: DW]}, 64'hD0);
      check("stall_valid", {63'd0, out_valid[2]}, 64'd1);
    end
    @(posedge wb_clk_i); #1;
    out_ready = 5'b11111;
    send_beat(32'hD1, 1'b0);
    send_beat(32'hD2, 1'b1);
    idle_cycles(3);
    check_drained("t3");
    check("t3_pops", 64'(pop_cnt[2]), 64'd9);

    // Zero grant blocks the input, then a single-beat packet to channel 1.
    gnt = 5'b00000; exp_mask = 5'b00010;
    in_valid = 1'b1; in_data = 32'hE0; in_last = 1'b1;
    repeat (4) begin
      @(negedge wb_clk_i);
      check("nogrant_ready", {63'd0, in_ready}, 64'd0);
      check("nogrant_busy", {63'd0, busy}, 64'd0);
    end
    @(posedge wb_clk_i); #1;
    gnt = 5'b00010;
    @(negedge wb_clk_i);
    check("grant_ready", {63'd0, in_ready}, 64'd1);
    @(posedge wb_clk_i); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("single_beat_idle", {63'd0, busy}, 64'd0);
    idle_cycles(2);
    check_drained("t4");
    check("t4_pops", 64'(pop_cnt[1]), 64'd1);

    // Multi-bit grant.
    serr_cnt = 0;
    gnt = 5'b10010;
`ifdef MI_DEMUX_BCAST_EN
    exp_mask = 5'b10010;
`else
    exp_mask = 5'b00010;
`endif
    send_beat(32'hF0, 1'b0);
    send_beat(32'hF1, 1'b1);
    idle_cycles(3);
    check_drained("t5");
`ifdef MI_DEMUX_BCAST_EN
    check("bcast_serr", 64'(serr_cnt), 64'd0);
    check("bcast_pops4", 64'(pop_cnt[4]), 64'd2);
    send_beat(32'hF8, 1'b0);
    out_ready = 5'b01111;
    in_valid = 1'b1; in_data = 32'hF9; in_last = 1'b1;
    repeat (2) begin
      @(negedge wb_clk_i);
      check("bcast_stall", {63'd0, in_ready}, 64'd0);
    end
    @(posedge wb_clk_i); #1;
    out_ready = 5'b11111;
    send_beat(32'hF9, 1'b1);
    idle_cycles(3);
    check_drained("t5b");
    check("bcast_pops1", 64'(pop_cnt[1]), 64'd5);
`else
    check("serr_pulse", 64'(serr_cnt), 64'd1);
    check("single_pops1", 64'(pop_cnt[1]), 64'd3);
    check("single_pops4", 64'(pop_cnt[4]), 64'd0);
`endif

    // Reset mid-packet discards the partial packet.
    gnt = 5'b00100; exp_mask = 5'b00100;
    send_beat(32'h70, 1'b0);
    wb_rst_n = 1'b0;
    #1;
    check("midrst_valid", {59'd0, out_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    for (int k = 0; k < NCH; k++) exp_q[k].delete();
    idle_cycles(2);
    wb_rst_n = 1'b1;
    idle_cycles(5);
    check("postrst_valid", {59'd0, out_valid}, 64'd0);
    check("postrst_busy", {63'd0, busy}, 64'd0);
    gnt = 5'b01000; exp_mask = 5'b01000;
    send_beat(32'h80, 1'b1);
    idle_cycles(3);
    check_drained("t6");
    check("t6_pops3", 64'(pop_cnt[3]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
